// File: rtl/param_bound_counter.sv
// Bounded up/down counter with runtime [lo, hi] bounds and four modes: saturate-up, wrap-up,
// ping-pong and saturate-down. Also provides a synchronous load, tc pulse and sticky done flag.
module param_bound_counter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RST_VAL = 5
) (
  input  logic             clck,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    ModeSatUp    = 2'b00,
    ModeWrapUp   = 2'b01,
    ModePingPong = 2'b10,
    ModeSatDown  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  mode_e            mode_q;
  mode_e            mode_cur;
  logic [WIDTH-1:0] cnt_inc, cnt_dec;
  logic             mode_chg;

  assign mode_cur = mode_e'(mode);
  assign cnt_inc  = count_q + 1'b1;
  assign cnt_dec  = count_q - 1'b1;
  assign mode_chg = (mode_cur != mode_q);
  assign cfg_err  = (lo >= hi);

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    done_d  = done_q;

    if (load) begin
      count_d = load_val;
      done_d  = 1'b0;
      dir_d   = (mode_cur != ModeSatDown);
    end else begin
      // done is scoped to a mode; entering sat-down also forces the down direction.
      if (mode_chg) begin
        done_d = 1'b0;
        if (mode_cur == ModeSatDown) dir_d = 1'b0;
      end

      if (en && !cfg_err) begin
        unique case (mode_cur)
          ModeSatUp: begin
            if (count_q < hi) begin
              count_d = cnt_inc;
              if (cnt_inc == hi) begin
                tc_d   = 1'b1;
                done_d = 1'b1;
              end
            end else begin
              done_d = 1'b1;
            end
          end
          ModeWrapUp: begin
            if (count_q < hi) begin
              count_d = cnt_inc;
            end else begin
              count_d = lo;
              tc_d    = 1'b1;
            end
          end
          ModePingPong: begin
            if (dir_q) begin
              if (count_q < hi) begin
                count_d = cnt_inc;
              end else begin
                count_d = cnt_dec;
                dir_d   = 1'b0;
                tc_d    = 1'b1;
              end
            end else begin
              if (count_q > lo) begin
                count_d = cnt_dec;
              end else begin
                count_d = cnt_inc;
                dir_d   = 1'b1;
                tc_d    = 1'b1;
              end
            end
          end
          ModeSatDown: begin
            if (count_q > lo) begin
              count_d = cnt_dec;
              if (cnt_dec == lo) begin
                tc_d   = 1'b1;
                done_d = 1'b1;
              end
            end else begin
              done_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      count_q <= WIDTH'(RST_VAL);
      dir_q   <= 1'b1;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= ModeSatUp;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      mode_q  <= mode_cur;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule
